cic_tc_sequencer: RTL and testbench

//   Sequences the lock-in CIC decimator: generates its tick strobe from a programmable prescaler and

---
 rtl/cic_tc_sequencer_pkg.sv | 15 +
 rtl/cic_tc_sequencer_if.sv | 22 ++
 rtl/cic_tc_sequencer_tick_gen.sv | 37 +++
 rtl/cic_tc_sequencer.sv | 134 +++++++++++++
 tb/tb_cic_tc_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_tc_sequencer_pkg.sv
// cic_seq_pkg: shared types and helpers for the CIC time-constant sequencer.
package cic_seq_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } seq_state_t;

    // The settle counter must hold STAGES << (2**tc_w - 1) without wrapping.
    function automatic int settle_w(input int tc_w, input int stages);
        return ((1 << tc_w) - 1) + $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/cic_tc_sequencer_if.sv
// cic_tc_sequencer_if: TC request handshake and the registered filter output stream.
interface cic_tc_sequencer_if #(
    parameter int TC_W = 4,
    parameter int DW   = 32
);
    logic [TC_W-1:0]      tc_req;
    logic                 tc_req_valid;
    logic                 tc_req_ready;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic                 settled;

    modport master (
        output tc_req, tc_req_valid,
        input  tc_req_ready, dout, dout_valid, settled
    );

    modport slave (
        input  tc_req, tc_req_valid,
        output tc_req_ready, dout, dout_valid, settled
    );
endinterface

// File: rtl/cic_tc_sequencer_tick_gen.sv
// cic_tick_gen: programmable prescaler producing a one-CLK tick strobe.
// tick_div is the reload value (CLK cycles per tick minus one), sampled at each reload.
module cic_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             reload,
    input  logic [DIV_W-1:0] tick_div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    // Down-counter; strobe and reload at zero, forced reload (no strobe) on request.
    // The count is not loaded at reset: the sequencer resets into a state that forces a reload
    // before any tick can be issued, so the reset value is never observed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (reload) begin
            r_cnt  <= tick_div;
            r_tick <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt  <= tick_div;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/cic_tc_sequencer.sv
// cic_tc_sequencer: owns the CIC time constant, issues its tick strobe and clear, and turns
// the CIC output into a valid-qualified stream. A TC change flushes the filter and holds off
// output for STAGES << tc ticks.
// Build option: define CIC_GAIN_COMP_EN to arithmetic-shift each output sample right by
// STAGES*cic_tc (CIC gain normalisation). Timing is the same in both builds.
module cic_tc_sequencer
    import cic_seq_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int TC_W   = 4,
    parameter int STAGES = 3,
    parameter int DW     = 32,
    parameter int TC_RST = 5
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [DIV_W-1:0]     tick_div,
    cic_tc_sequencer_if.slave    tc_if,
    output logic                 cic_tick,
    output logic [TC_W-1:0]      cic_tc,
    output logic                 cic_clear,
    input  logic signed [DW-1:0] cic_out
);

    localparam int SETTLE_W = settle_w(TC_W, STAGES);

    seq_state_t           r_state;
    logic [TC_W-1:0]      r_tc;
    logic [SETTLE_W-1:0]  r_settle;
    logic                 r_clear;
    logic                 r_ready;
    logic                 r_settled;
    logic signed [DW-1:0] r_dout;
    logic                 r_dout_valid;

    logic                 w_tick;
    logic                 w_accept;
    logic                 w_change;
    logic                 w_reload;
    logic                 w_capture;
    logic [SETTLE_W-1:0]  w_settle_load;
    logic signed [DW-1:0] w_dout_next;

    // r_ready is high exactly in RUN, so it doubles as the accept qualifier.
    assign w_accept      = r_ready && tc_if.tc_req_valid;
    assign w_change      = w_accept && (tc_if.tc_req != r_tc);
    // Reloading on the accept edge as well as in CLEAR keeps cic_tick low during CLEAR.
    assign w_reload      = (r_state == ST_CLEAR) || w_change;
    assign w_capture     = w_tick && (r_state == ST_RUN);
    assign w_settle_load = SETTLE_W'(STAGES) << r_tc;

`ifdef CIC_GAIN_COMP_EN
    assign w_dout_next = cic_out >>> (STAGES * int'(r_tc));
`else
    assign w_dout_next = cic_out;
`endif

    cic_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .reload   (w_reload),
        .tick_div (tick_div),
        .tick     (w_tick)
    );

    // Flush-and-settle sequencer with registered clear/ready/settled outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_CLEAR;
            r_tc      <= TC_W'(TC_RST);
            r_settle  <= '0;
            r_clear   <= 1'b1;
            r_ready   <= 1'b0;
            r_settled <= 1'b0;
        end else begin
            unique case (r_state)
                ST_CLEAR: begin
                    r_settle <= w_settle_load;
                    r_clear  <= 1'b0;
                    r_state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_tick) begin
                        r_settle <= r_settle - 1'b1;
                        if (r_settle == SETTLE_W'(1)) begin
                            r_state   <= ST_RUN;
                            r_ready   <= 1'b1;
                            r_settled <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_change) begin
                        r_tc      <= tc_if.tc_req;
                        r_state   <= ST_CLEAR;
                        r_clear   <= 1'b1;
                        r_ready   <= 1'b0;
                        r_settled <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clear   <= 1'b1;
                    r_ready   <= 1'b0;
                    r_settled <= 1'b0;
                end
            endcase
        end
    end

    // Output register: one sample per tick issued in RUN, using the TC in force at that tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_capture;
            if (w_capture) begin
                r_dout <= w_dout_next;
            end
        end
    end

    assign cic_tick           = w_tick;
    assign cic_tc             = r_tc;
    assign cic_clear          = r_clear;
    assign tc_if.tc_req_ready = r_ready;
    assign tc_if.settled      = r_settled;
    assign tc_if.dout         = r_dout;
    assign tc_if.dout_valid   = r_dout_valid;

endmodule

// File: tb/tb_cic_tc_sequencer.sv
// tb_cic_tc_sequencer: directed bench for cic_tc_sequencer with a data scoreboard.
// Honours CIC_GAIN_COMP_EN when the build defines it.
module tb_cic_tc_sequencer;

`ifdef CIC_GAIN_COMP_EN
    localparam bit GAIN_EN = 1'b1;
`else
    localparam bit GAIN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] tick_div;
    logic        cic_tick;
    logic [3:0]  cic_tc;
    logic        cic_clear;
    logic [31:0] cic_out;

    logic        use_fixed;
    logic [31:0] fixed_val;
    int          m_tc;
    int          n_vec;
    int          n_err;
    logic [31:0] sb_q[$];

    cic_tc_sequencer_if #(.TC_W(4), .DW(32)) u_if ();

    cic_tc_sequencer #(
        .DIV_W  (16),
        .TC_W   (4),
        .STAGES (3),
        .DW     (32),
        .TC_RST (5)
    ) u_dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .tick_div  (tick_div),
        .tc_if     (u_if.slave),
        .cic_tick  (cic_tick),
        .cic_tc    (cic_tc),
        .cic_clear (cic_clear),
        .cic_out   (cic_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_dout(input logic [31:0] v, input int tc);
        logic signed [31:0] s;
        s = v;
        return s >>> (GAIN_EN ? 3 * tc : 0);
    endfunction

    // Steps negedges until cic_tick is seen; gap = negedges advanced, -1 on timeout.
    task automatic wait_tick(input int limit, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (cic_tick !== 1'b1 && gap < limit);
        if (cic_tick !== 1'b1) gap = -1;
    endtask

    task automatic settle_run(input string tag, input int nticks, input int first_gap, input int period);
        int gap;
        int bad_gap;
        int early;
        bad_gap = 0;
        early   = 0;
        for (int i = 0; i < nticks; i++) begin
            wait_tick(64, gap);
            if (gap != ((i == 0) ? first_gap : period)) bad_gap++;
            if (u_if.settled !== 1'b0 || u_if.tc_req_ready !== 1'b0 || cic_clear !== 1'b0) early++;
        end
        check({tag, "_tick_gaps_bad"}, 32'(bad_gap), 32'd0);
        check({tag, "_early_run"}, 32'(early), 32'd0);
        @(negedge clk);
        check({tag, "_settled"}, 32'(u_if.settled), 32'd1);
        check({tag, "_ready"}, 32'(u_if.tc_req_ready), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cic_tc"}, 32'(cic_tc), 32'd5);
        check({tag, "_cic_tick"}, 32'(cic_tick), 32'd0);
        check({tag, "_cic_clear"}, 32'(cic_clear), 32'd1);
        check({tag, "_dout"}, u_if.dout, 32'd0);
        check({tag, "_dout_valid"}, 32'(u_if.dout_valid), 32'd0);
        check({tag, "_settled"}, 32'(u_if.settled), 32'd0);
        check({tag, "_ready"}, 32'(u_if.tc_req_ready), 32'd0);
    endtask

    // CIC output model: new value just after every edge, fixed or random.
    initial begin
        cic_out = '0;
        forever begin
            @(posedge clk);
            #1;
            cic_out = use_fixed ? fixed_val : $urandom();
        end
    end

    // Scoreboard: push on each tick seen in RUN, pop on each dout_valid.
    always @(negedge clk) begin
        if (u_if.dout_valid === 1'b1) begin
            check("sb_pending", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() > 0) check("sb_dout", u_if.dout, sb_q.pop_front());
        end
        if (cic_tick === 1'b1 && u_if.settled === 1'b1) sb_q.push_back(model_dout(cic_out, m_tc));
    end

    initial begin
        int gap;
        int bad;
        n_vec             = 0;
        n_err             = 0;
        rst_n             = 1'b0;
        tick_div          = 16'd4;
        u_if.tc_req       = '0;
        u_if.tc_req_valid = 1'b0;
        use_fixed         = 1'b0;
        fixed_val         = '0;
        m_tc              = 5;

        // Reset values, then power-up flush: 96 ticks 5 CLK apart.
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        #1;
        check("t1_clear_after_release", 32'(cic_clear), 32'd1);
        settle_run("t1", 96, 6, 5);
        wait_tick(64, gap);
        check("t1_first_run_tick_gap", 32'(gap), 32'd4);
        check("t1_no_valid_from_settle_tick", 32'(u_if.dout_valid), 32'd0);
        @(negedge clk);
        check("t1_first_valid", 32'(u_if.dout_valid), 32'd1);

        // Request equal to the current TC: accepted without a flush.
        u_if.tc_req       = 4'd5;
        u_if.tc_req_valid = 1'b1;
        @(negedge clk);
        check("t3_ready", 32'(u_if.tc_req_ready), 32'd1);
        check("t3_no_clear", 32'(cic_clear), 32'd0);
        check("t3_settled", 32'(u_if.settled), 32'd1);
        check("t3_tc", 32'(cic_tc), 32'd5);
        u_if.tc_req_valid = 1'b0;
        wait_tick(64, gap);
        check("t3_gap_a", 32'(gap), 32'd3);

        // Gain compensation check points (tc=5).
        use_fixed = 1'b1;
        fixed_val = 32'h4000_0000;
        wait_tick(64, gap);
        check("t3_gap_b", 32'(gap), 32'd5);
        @(negedge clk);
        check("t6_pos", u_if.dout, GAIN_EN ? 32'h0000_8000 : 32'h4000_0000);
        fixed_val = 32'h8000_0000;
        wait_tick(64, gap);
        check("t6_gap", 32'(gap), 32'd4);
        @(negedge clk);
        check("t6_neg", u_if.dout, GAIN_EN ? 32'hFFFF_0000 : 32'h8000_0000);
        use_fixed = 1'b0;
        wait_tick(64, gap);

        // Accept coincident with a RUN tick: flush to tc=2, old-TC sample valid in CLEAR.
        u_if.tc_req       = 4'd2;
        u_if.tc_req_valid = 1'b1;
        @(negedge clk);
        check("t2_clear", 32'(cic_clear), 32'd1);
        check("t2_tc", 32'(cic_tc), 32'd2);
        check("t2_ready_low", 32'(u_if.tc_req_ready), 32'd0);
        check("t2_settled_low", 32'(u_if.settled), 32'd0);
        check("t2_valid_in_clear", 32'(u_if.dout_valid), 32'd1);
        check("t2_no_tick_in_clear", 32'(cic_tick), 32'd0);
        u_if.tc_req_valid = 1'b0;
        m_tc = 2;
        settle_run("t2", 12, 6, 5);

        // Request held through SETTLE is taken on the first RUN cycle.
        u_if.tc_req       = 4'd3;
        u_if.tc_req_valid = 1'b1;
        @(negedge clk);
        check("t4_tc3", 32'(cic_tc), 32'd3);
        u_if.tc_req = 4'd4;
        m_tc = 3;
        settle_run("t4a", 24, 6, 5);
        check("t4_not_taken_early", 32'(cic_tc), 32'd3);
        @(negedge clk);
        check("t4_clear", 32'(cic_clear), 32'd1);
        check("t4_tc4", 32'(cic_tc), 32'd4);
        u_if.tc_req_valid = 1'b0;
        m_tc = 4;
        settle_run("t4b", 48, 6, 5);

        // Prescaler: tick every CLK, then 2 -> 7 change mid-count.
        tick_div = 16'd0;
        wait_tick(64, gap);
        check("t5_gap_to_div0", 32'(gap), 32'd4);
        bad = 0;
        repeat (8) begin
            wait_tick(64, gap);
            if (gap != 1) bad++;
        end
        check("t5_every_clk", 32'(bad), 32'd0);
        tick_div = 16'd2;
        wait_tick(64, gap);
        check("t5_gap_last_div0", 32'(gap), 32'd1);
        wait_tick(64, gap);
        check("t5_gap_div2", 32'(gap), 32'd3);
        @(negedge clk);
        tick_div = 16'd7;
        wait_tick(64, gap);
        check("t5_gap_old_period_kept", 32'(gap), 32'd2);
        wait_tick(64, gap);
        check("t5_gap_div7", 32'(gap), 32'd8);
        tick_div = 16'd4;
        wait_tick(64, gap);
        check("t5_gap_div7_again", 32'(gap), 32'd8);
        wait_tick(64, gap);
        check("t5_gap_div4", 32'(gap), 32'd5);

        // Asynchronous reset in the middle of a settle.
        u_if.tc_req       = 4'd1;
        u_if.tc_req_valid = 1'b1;
        @(negedge clk);
        check("rst_tc1", 32'(cic_tc), 32'd1);
        u_if.tc_req_valid = 1'b0;
        m_tc = 1;
        wait_tick(64, gap);
        wait_tick(64, gap);
        check("rst_second_settle_tick", 32'(gap), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        m_tc = 5;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_restart_clear", 32'(cic_clear), 32'd1);
        settle_run("rst", 96, 6, 5);
        wait_tick(64, gap);
        check("rst_first_run_tick_gap", 32'(gap), 32'd4);
        @(negedge clk);
        check("rst_first_valid", 32'(u_if.dout_valid), 32'd1);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
